ripple_counter_sequencer: RTL and testbench

Synchronous controller that runs the 3-bit DFF ripple up-counter to a requested terminal value and reports completion. It clears the counter, issues one clock pulse per step, waits a settle window for the ripple to propagate, and checks the returned count against an internally tracked expected value. It sits between a requester using a start/done handshake and the counter's clock and active-low clear inputs. A mismatch between the returned count and the expected value raises a sticky error.

---
 rtl/ripple_counter_sequencer_if.sv | 30 +++
 rtl/ripple_counter_sequencer.sv | 120 ++++++++++++
 tb/tb_ripple_counter_sequencer.sv | 197 +++++++++++++++++++
 3 files changed

// File: rtl/ripple_counter_sequencer_if.sv
// Requester-side handshake between a run initiator and the ripple counter sequencer.
// The master drives the request; the slave (sequencer) reports progress and status.
interface ripple_counter_sequencer_if #(
    parameter int CW = 3
);
    logic          start;
    logic [CW-1:0] target;
    logic          busy;
    logic          done;
    logic          err;
    logic [CW-1:0] step;

    modport master (
        output start,
        output target,
        input  busy,
        input  done,
        input  err,
        input  step
    );

    modport slave (
        input  start,
        input  target,
        output busy,
        output done,
        output err,
        output step
    );
endinterface

// File: rtl/ripple_counter_sequencer.sv
// Clears the ripple counter, ticks it up to the requested target, and after each
// settle window checks the returned count against the expected value (sticky error).
//
// state  | meaning
// IDLE   | waiting for start; counter clear released, no tick
// CLEAR  | counter clear asserted for one cycle
// SETTLE | down-counter holds while the ripple propagates
// CHECK  | compare returned count with expected step
// TICK   | one counter clock pulse, expected step advances
// DONE   | one-cycle completion pulse
// ERR    | mismatch seen; held until reset
module ripple_counter_sequencer #(
    parameter int CW     = 3,
    parameter int SETTLE = 2
) (
    input  logic                        Clk,
    input  logic                        Clr,
    ripple_counter_sequencer_if.slave   req,
    input  logic [CW-1:0]               count,
    output logic                        cnt_ClrN,
    output logic                        cnt_tick
);
    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_CLEAR  = 3'd1;
    localparam logic [2:0] S_SETTLE = 3'd2;
    localparam logic [2:0] S_CHECK  = 3'd3;
    localparam logic [2:0] S_TICK   = 3'd4;
    localparam logic [2:0] S_DONE   = 3'd5;
    localparam logic [2:0] S_ERR    = 3'd6;

    localparam int SW = (SETTLE > 1) ? $clog2(SETTLE) : 1;
    // The SETTLE state lasts load+1 cycles, so load one less than the window.
    localparam logic [SW-1:0] SETTLE_LOAD = SW'(SETTLE - 1);

    logic [2:0]    state_q, state_d;
    logic [SW-1:0] settle_q, settle_d;
    logic [CW-1:0] exp_q, exp_d;
    logic [CW-1:0] tgt_q, tgt_d;
    logic          clrn_q, tick_q, busy_q, done_q, err_q;
    logic          run_d;

    always_comb begin
        state_d  = state_q;
        settle_d = settle_q;
        exp_d    = exp_q;
        tgt_d    = tgt_q;
        case (state_q)
            S_IDLE: begin
                if (req.start) begin
                    tgt_d   = req.target;
                    exp_d   = '0;
                    state_d = S_CLEAR;
                end
            end
            S_CLEAR: begin
                settle_d = SETTLE_LOAD;
                state_d  = S_SETTLE;
            end
            S_SETTLE: begin
                if (settle_q == '0) begin
                    state_d = S_CHECK;
                end else begin
                    settle_d = settle_q - 1'b1;
                end
            end
            S_CHECK: begin
                if (count != exp_q) begin
                    state_d = S_ERR;
                end else if (exp_q == tgt_q) begin
                    state_d = S_DONE;
                end else begin
                    state_d = S_TICK;
                end
            end
            S_TICK: begin
                exp_d    = exp_q + 1'b1;
                settle_d = SETTLE_LOAD;
                state_d  = S_SETTLE;
            end
            S_DONE:  state_d = S_IDLE;
            S_ERR:   state_d = S_ERR;
            default: state_d = S_IDLE;
        endcase
    end

    assign run_d = (state_d == S_CLEAR) || (state_d == S_SETTLE) || (state_d == S_CHECK) ||
                   (state_d == S_TICK)  || (state_d == S_DONE);

    // Outputs are registered from the next state so they line up with the state itself.
    always_ff @(posedge Clk) begin
        if (Clr) begin
            state_q  <= S_IDLE;
            settle_q <= '0;
            exp_q    <= '0;
            tgt_q    <= '0;
            clrn_q   <= 1'b0;
            tick_q   <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            settle_q <= settle_d;
            exp_q    <= exp_d;
            tgt_q    <= tgt_d;
            clrn_q   <= (state_d != S_CLEAR);
            tick_q   <= (state_d == S_TICK);
            busy_q   <= run_d;
            done_q   <= (state_d == S_DONE);
            err_q    <= (state_d == S_ERR);
        end
    end

    assign cnt_ClrN = clrn_q;
    assign cnt_tick = tick_q;
    assign req.busy = busy_q;
    assign req.done = done_q;
    assign req.err  = err_q;
    assign req.step = exp_q;
endmodule

// File: tb/tb_ripple_counter_sequencer.sv
// Scoreboard bench: each run pushes its expected outcome; a negedge monitor pops and
// compares on done, err rise, or reset abort, and checks every tick's cycle position.
module tb_ripple_counter_sequencer;
    localparam int CW = 3;
    localparam int S  = 2;
    localparam int K_DONE  = 0;
    localparam int K_ERR   = 1;
    localparam int K_ABORT = 2;

    typedef struct {
        int kind;
        int s;
        int rel;
        int ticks;
        int step;
    } exp_t;

    logic          clk;
    logic          clr;
    logic [CW-1:0] count_m;
    logic          cnt_ClrN;
    logic          cnt_tick;
    logic          stuck;
    int            cyc;
    int            checks;
    int            errors;
    int            tick_cnt;
    logic          err_prev;
    exp_t          sb[$];
    exp_t          me;
    int            kind;

    ripple_counter_sequencer_if #(.CW(CW)) rif ();

    ripple_counter_sequencer #(.CW(CW), .SETTLE(S)) dut (
        .Clk      (clk),
        .Clr      (clr),
        .req      (rif),
        .count    (count_m),
        .cnt_ClrN (cnt_ClrN),
        .cnt_tick (cnt_tick)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Behavioural ripple counter: clear and advance become visible one cycle later.
    always @(posedge clk) begin
        if (cnt_ClrN === 1'b0) count_m <= '0;
        else if (cnt_tick === 1'b1 && !stuck) count_m <= count_m + 1'b1;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic go(input int t, input int k, input int rel, input int ticks, input int stp);
        exp_t e;
        @(negedge clk);
        rif.start  = 1'b1;
        rif.target = t[CW-1:0];
        e.kind  = k;
        e.s     = cyc;
        e.rel   = rel;
        e.ticks = ticks;
        e.step  = stp;
        sb.push_back(e);
        @(negedge clk);
        rif.start = 1'b0;
    endtask

    initial begin
        tick_cnt = 0;
        err_prev = 1'b0;
    end

    always @(negedge clk) begin
        if (cnt_tick === 1'b1) begin
            chk("tick_expected", sb.size() != 0, 1);
            if (sb.size() != 0)
                chk("tick_cycle", cyc - sb[0].s, S + 3 + tick_cnt * (S + 2));
            tick_cnt++;
        end
        if (rif.done === 1'b1 || (rif.err === 1'b1 && !err_prev)) begin
            kind = (rif.done === 1'b1) ? K_DONE : K_ERR;
            chk("event_expected", sb.size() != 0, 1);
            if (sb.size() != 0) begin
                me = sb.pop_front();
                chk("event_kind", kind, me.kind);
                chk("event_cycle", cyc - me.s, me.rel);
                chk("event_step", rif.step, me.step);
                chk("event_ticks", tick_cnt, me.ticks);
                chk("event_busy", rif.busy, (me.kind == K_DONE) ? 1 : 0);
                chk("event_err", rif.err, (me.kind == K_ERR) ? 1 : 0);
            end
        end
        if (cnt_ClrN === 1'b0) begin
            if (rif.busy === 1'b0 && sb.size() != 0 && sb[0].kind == K_ABORT) begin
                me = sb.pop_front();
                chk("abort_cycle", cyc - me.s, me.rel);
                chk("abort_ticks", tick_cnt, me.ticks);
                chk("abort_done", rif.done, 0);
            end
            tick_cnt = 0;
        end
        err_prev = (rif.err === 1'b1);
    end

    initial begin
        checks     = 0;
        errors     = 0;
        stuck      = 1'b0;
        clr        = 1'b1;
        rif.start  = 1'b1;
        rif.target = 3'd3;

        // Reset held three cycles with start asserted
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("rst_clrn", cnt_ClrN, 0);
            chk("rst_busy", rif.busy, 0);
            chk("rst_done", rif.done, 0);
            chk("rst_err", rif.err, 0);
            chk("rst_step", rif.step, 0);
        end
        clr       = 1'b0;
        rif.start = 1'b0;
        @(negedge clk);
        chk("rel_clrn", cnt_ClrN, 1);
        chk("rel_busy", rif.busy, 0);
        @(negedge clk);
        chk("rel_busy2", rif.busy, 0);

        // Normal run, target 5: done at cycle 25
        go(5, K_DONE, 25, 5, 5);
        repeat (25) @(negedge clk);

        // Extremes: target 0 then target 7 started in the cycle after done
        go(0, K_DONE, 5, 0, 0);
        repeat (4) @(negedge clk);
        go(7, K_DONE, 33, 7, 7);
        repeat (33) @(negedge clk);

        // Stuck counter, target 3: mismatch in CHECK cycle 8, err from cycle 9
        stuck = 1'b1;
        go(3, K_ERR, 9, 1, 1);
        repeat (9) @(negedge clk);
        rif.start  = 1'b1;
        rif.target = 3'd2;
        @(negedge clk);
        rif.start = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("err_hold_busy", rif.busy, 0);
            chk("err_hold_err", rif.err, 1);
        end
        clr   = 1'b1;
        stuck = 1'b0;
        @(negedge clk);
        chk("err_clr_err", rif.err, 0);
        chk("err_clr_clrn", cnt_ClrN, 0);
        clr = 1'b0;
        @(negedge clk);
        chk("err_rel_clrn", cnt_ClrN, 1);

        // Ignored inputs: start pulse and target change at cycle 10 of a target 5 run
        go(5, K_DONE, 25, 5, 5);
        repeat (9) @(negedge clk);
        rif.start  = 1'b1;
        rif.target = 3'd1;
        @(negedge clk);
        rif.start = 1'b0;
        repeat (15) @(negedge clk);

        // Mid-run reset at cycle 14 of a target 5 run, then a target 2 run
        go(5, K_ABORT, 15, 3, 0);
        repeat (13) @(negedge clk);
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        repeat (6) @(negedge clk);
        go(2, K_DONE, 13, 2, 2);
        repeat (14) @(negedge clk);

        repeat (2) @(negedge clk);
        chk("sb_drained", sb.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
